tb_wr_seq: RTL and testbench
============================

# tb_wr_seq

Write sequencer for the temp buffer (TB) port-A path. It accepts one transfer command at a time and issues sequential CB port-A reads or counts non-linear-unit beats. It holds the TB input-mux select (`TB_dina_sel`, `l_k_0`) stable for the whole command and generates the TB write strobe, per-element write mask and address. All three are aligned to the one-cycle registered data path of the TB input mux, which sits directly downstream and feeds TB port A.

## Interface
- `L`, 4, elements per TB word (mask width)
- `RSA_DW`, 32, element width (documentation only; no data passes through this block)
- `TB_DINA_SEL_DW`, 3, mux select width: bit 2 = source (0 CB, 1 non-linear), bits 1:0 = dir (00 IDLE, 01 POS, 10 NEG, 11 NEW)
- `CB_AW`, 10, CB address width
- `TB_AW`, 10, TB address width
- `LEN_W`, 8, beat-count width

Ports:
- `clk`  in  1  system clock, all logic on rising edge
- `sys_rst_n`  in  1  asynchronous, active-low reset
- `cmd_valid`  in  1  command request
- `cmd_ready`  out  1  high in IDLE only
- `cmd_src`  in  1  0 = CB, 1 = non-linear
- `cmd_dir`  in  2  direction code as above
- `cmd_l_k_0`  in  1  NEW-mode half select
- `cmd_cb_base`  in  CB_AW  CB start address
- `cmd_tb_base`  in  TB_AW  TB start address
- `cmd_len`  in  LEN_W  number of beats
- `nl_valid`  in  1  non-linear data beat valid on `TB_dina_non_linear`
- `nl_ready`  out  1  high while an NL command has beats remaining
- `CB_ena`  out  1  CB port-A read enable
- `CB_addra`  out  CB_AW  CB read address
- `TB_dina_sel`  out  TB_DINA_SEL_DW  to mux
- `l_k_0`  out  1  to mux
- `TB_wea`  out  L  per-element write enable
- `TB_addra`  out  TB_AW  TB write address
- `busy`  out  1  high from accept until done
- `done`  out  1  one-cycle pulse after last write

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- **IDLE:**
  - `cmd_ready`=1.
  - On `cmd_valid`, latch all command fields.
  - Register `TB_dina_sel`={`cmd_src`,`cmd_dir`} and `l_k_0`=`cmd_l_k_0`; both hold unchanged until DONE.
  - Go to RUN, or straight to DONE if `cmd_len`=0.
- **RUN, CB source:**
  - One read per cycle, `CB_ena`=1, for `cmd_len` consecutive cycles.
  - Addresses are `cb_base`, `cb_base`+1, … for every dir, including NEG, where element reversal is done by the mux.
  - After the last issue go to DRAIN.
- **RUN, NL source:**
  - `nl_ready`=1.
  - Each cycle with `nl_valid`=1 counts one beat.
  - `nl_valid` outside an NL RUN is ignored.
  - After the last beat go to DRAIN.
- **DRAIN:** wait until the write pipeline is empty, then go to DONE.
- **DONE:** `done`=1 for one cycle; `TB_dina_sel`, `l_k_0` return to 0; go to IDLE.
- **Write mask per beat:**
  - POS, NEG, IDLE: all ones. IDLE clears rows to zero.
  - NEW with `l_k_0`=1: `4'b0011`.
  - NEW with `l_k_0`=0: `4'b1100`.
- `TB_addra` = `tb_base` + beat index, wrapping modulo 2^TB_AW. `CB_addra` wraps modulo 2^CB_AW.
- Beat counter is LEN_W wide; `cmd_len` = 2^LEN_W−1 is the maximum.
- **Reset (any time, including mid-command):**
  - All outputs go to 0 immediately: `cmd_ready`, `CB_ena`, `TB_wea`, `TB_dina_sel`, `l_k_0`, `busy`, `done`, `nl_ready`, addresses.
  - On release, state is IDLE and `cmd_ready`=1 from the first clock edge.
  - A partial transfer is abandoned; no write is issued after reset.

## Timing
- Accept at edge E0. `TB_dina_sel` is valid from E0, one cycle before first data reaches the mux.
- **CB source:**
  - First `CB_ena` in the cycle after E0.
  - A read issued in cycle c produces `TB_wea`≠0 in cycle c+2: 1 cycle BRAM latency, 1 cycle mux register.
  - Throughput is 1 beat/cycle.
- **NL source:** `nl_valid` in cycle t produces its write in cycle t+1. Bubbles are allowed.
- `done` is asserted in the cycle after the last `TB_wea`.
- `busy` is high from the cycle after E0 through the `done` cycle.
- `cmd_ready` returns high the cycle after `done`. The minimum gap between commands is therefore 1 idle cycle.
- `cmd_valid` while `busy` is ignored (not queued).

## Test plan
- **CB POS:** base CB 0x010, TB 0x020, len 4.
  - `CB_ena` high 4 cycles at addresses 0x010–0x013.
  - `TB_wea`=4'b1111 at TB 0x020–0x023, each 2 cycles after its read.
  - `done` 1 cycle after the last write.
- **NEW mode:** `l_k_0`=0, len 2 → `TB_wea`=4'b1100 twice. Repeat with `l_k_0`=1 → 4'b0011. Sel reads 3'b011 throughout.
- **NL with bubbles:** NL POS, len 3, `nl_valid` pattern 1,0,0,1,1.
  - Writes appear exactly one cycle after each valid, at TB base+0..2.
  - `nl_ready` drops after the third beat.
  - A 4th `nl_valid` produces no write.
- **len=0 and wrap:**
  - len 0 → `done` the cycle after accept, no `CB_ena`, no `TB_wea`.
  - TB base 0x3FE, len 3 → TB addresses 0x3FE, 0x3FF, 0x000.
- **Reset mid-transfer:** assert `sys_rst_n` low between clock edges during the 2nd CB beat of a len-8 command.
  - All outputs 0 immediately, with no further `TB_wea`.
  - After release, a new len-1 command completes normally.
- **Back-to-back:** a second `cmd_valid` held during `busy` is ignored, then accepted the cycle after `done`. Sel switches to the new value only at that accept.

Source files
------------

// File: rtl/tb_wr_seq.sv
// rtl/tb_wr_seq.sv - temp buffer port-A write sequencer
//
// Takes one transfer command at a time. CB-sourced commands issue sequential
// CB port-A reads (one per cycle). NL-sourced commands count non-linear data
// beats. The TB input-mux select is held for the whole command. The TB write
// strobe, mask and address are delayed to line up with the mux's registered
// data path: CB read in cycle c writes in c+2, NL beat in cycle t writes in t+1.
//
// Ports:
//   clk, sys_rst_n          clock, asynchronous active-low reset
//   cmd_valid / cmd_ready   command handshake (ready only in IDLE)
//   cmd_src, cmd_dir,
//   cmd_l_k_0               mux source, direction and NEW-mode half select
//   cmd_cb_base, cmd_tb_base,
//   cmd_len                 CB/TB start addresses and beat count
//   nl_valid / nl_ready     non-linear beat handshake
//   CB_ena, CB_addra        CB port-A read enable and address
//   TB_dina_sel, l_k_0      TB input-mux controls
//   TB_wea, TB_addra        TB port-A per-element write enable and address
//   busy, done              command in progress / completion pulse

module tb_wr_seq #(
   parameter int unsigned L              = 4,
   parameter int unsigned RSA_DW         = 32,
   parameter int unsigned TB_DINA_SEL_DW = 3,
   parameter int unsigned CB_AW          = 10,
   parameter int unsigned TB_AW          = 10,
   parameter int unsigned LEN_W          = 8
) (
   input  logic                      clk,
   input  logic                      sys_rst_n,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic                      cmd_src,
   input  logic [1:0]                cmd_dir,
   input  logic                      cmd_l_k_0,
   input  logic [CB_AW-1:0]          cmd_cb_base,
   input  logic [TB_AW-1:0]          cmd_tb_base,
   input  logic [LEN_W-1:0]          cmd_len,
   input  logic                      nl_valid,
   output logic                      nl_ready,
   output logic                      CB_ena,
   output logic [CB_AW-1:0]          CB_addra,
   output logic [TB_DINA_SEL_DW-1:0] TB_dina_sel,
   output logic                      l_k_0,
   output logic [L-1:0]              TB_wea,
   output logic [TB_AW-1:0]          TB_addra,
   output logic                      busy,
   output logic                      done
);

   // No data passes through here; RSA_DW is only sanity-checked.
   if (RSA_DW == 0 || L < 2 || (L % 2) != 0 || TB_DINA_SEL_DW < 3) begin : g_bad_param
      $error("tb_wr_seq: unsupported parameter set");
   end

   localparam logic [L-1:0] LO_HALF = L'((1 << (L/2)) - 1);
   localparam logic [1:0]   DIR_NEW = 2'b11;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t                    state_q, state_d;
   logic                      init_q;
   logic [TB_DINA_SEL_DW-1:0] sel_q;
   logic                      lk_q;
   logic [CB_AW-1:0]          cb_base_q;
   logic [TB_AW-1:0]          tb_base_q;
   logic [LEN_W-1:0]          len_q;
   logic [LEN_W-1:0]          idx_q, idx_d;
   logic                      p1_vld_q;
   logic [TB_AW-1:0]          p1_addr_q;
   logic                      wr_vld_q;
   logic [TB_AW-1:0]          wr_addr_q;

   logic                      accept;
   logic                      cb_issue;
   logic                      nl_beat;
   logic                      last_beat;
   logic [TB_AW-1:0]          beat_addr;
   logic [L-1:0]              mask;

   // init_q keeps cmd_ready low until the first edge after reset release.
   assign accept    = (state_q == S_IDLE) && init_q && cmd_valid;
   assign cb_issue  = (state_q == S_RUN) && !sel_q[2];
   assign nl_beat   = (state_q == S_RUN) &&  sel_q[2] && nl_valid;
   assign last_beat = (idx_q == len_q - LEN_W'(1));
   assign beat_addr = tb_base_q + TB_AW'(idx_q);

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cmd_ready = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      CB_ena    = 1'b0;
      nl_ready  = 1'b0;
      case (state_q)
         S_IDLE: begin
            cmd_ready = init_q;
            if (accept) begin
               idx_d   = '0;
               state_d = (cmd_len == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            busy     = 1'b1;
            CB_ena   = cb_issue;
            nl_ready = sel_q[2];
            if (cb_issue || nl_beat) begin
               idx_d = idx_q + LEN_W'(1);
               if (last_beat) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            busy = 1'b1;
            // Once stage 1 is empty, the write stage holds the final write
            // (if any), so done lands exactly one cycle after it.
            if (!p1_vld_q) state_d = S_DONE;
         end
         S_DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      mask = '1;
      if (sel_q[1:0] == DIR_NEW) mask = lk_q ? LO_HALF : ~LO_HALF;
   end

   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q   <= S_IDLE;
         init_q    <= 1'b0;
         idx_q     <= '0;
         sel_q     <= '0;
         lk_q      <= 1'b0;
         cb_base_q <= '0;
         tb_base_q <= '0;
         len_q     <= '0;
         p1_vld_q  <= 1'b0;
         p1_addr_q <= '0;
         wr_vld_q  <= 1'b0;
         wr_addr_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         init_q  <= 1'b1;
         if (accept) begin
            sel_q     <= TB_DINA_SEL_DW'({cmd_src, cmd_dir});
            lk_q      <= cmd_l_k_0;
            cb_base_q <= cmd_cb_base;
            tb_base_q <= cmd_tb_base;
            len_q     <= cmd_len;
         end else if (state_q == S_DONE) begin
            sel_q <= '0;
            lk_q  <= 1'b0;
         end
         // Stage 1 models the BRAM read latency; the write stage models the
         // mux output register. NL beats enter the write stage directly.
         p1_vld_q  <= cb_issue;
         p1_addr_q <= beat_addr;
         wr_vld_q  <= p1_vld_q | nl_beat;
         wr_addr_q <= nl_beat ? beat_addr : p1_addr_q;
      end
   end

   assign CB_addra    = cb_issue ? cb_base_q + CB_AW'(idx_q) : '0;
   assign TB_wea      = wr_vld_q ? mask : '0;
   assign TB_addra    = wr_vld_q ? wr_addr_q : '0;
   assign TB_dina_sel = sel_q;
   assign l_k_0       = lk_q;

endmodule

// File: tb/tb_tb_wr_seq.sv
// tb/tb_tb_wr_seq.sv - scoreboard testbench for tb_wr_seq

module tb_tb_wr_seq;

   logic        clk = 1'b0;
   logic        sys_rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_src;
   logic [1:0]  cmd_dir;
   logic        cmd_l_k_0;
   logic [9:0]  cmd_cb_base;
   logic [9:0]  cmd_tb_base;
   logic [7:0]  cmd_len;
   logic        nl_valid;
   logic        nl_ready;
   logic        CB_ena;
   logic [9:0]  CB_addra;
   logic [2:0]  TB_dina_sel;
   logic        l_k_0;
   logic [3:0]  TB_wea;
   logic [9:0]  TB_addra;
   logic        busy;
   logic        done;

   tb_wr_seq dut (
      .clk(clk), .sys_rst_n(sys_rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_src(cmd_src), .cmd_dir(cmd_dir), .cmd_l_k_0(cmd_l_k_0),
      .cmd_cb_base(cmd_cb_base), .cmd_tb_base(cmd_tb_base), .cmd_len(cmd_len),
      .nl_valid(nl_valid), .nl_ready(nl_ready),
      .CB_ena(CB_ena), .CB_addra(CB_addra),
      .TB_dina_sel(TB_dina_sel), .l_k_0(l_k_0),
      .TB_wea(TB_wea), .TB_addra(TB_addra),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      int         cyc;
      logic [9:0] addr;
      logic [3:0] mask;
   } ev_t;

   ev_t cb_q[$];
   ev_t wr_q[$];
   int  done_q[$];

   bit  nl_pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
   int  k;
   int  ka;

   task automatic chk(input string name, input longint act, input longint exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic fail_now(input string name);
      n_total++;
      $display("FAIL %s: got event expected none (cycle %0d)", name, cyc);
   endtask

   function automatic logic [3:0] exp_mask(input logic [1:0] dir, input logic lk);
      if (dir == 2'b11) return lk ? 4'b0011 : 4'b1100;
      return 4'b1111;
   endfunction

   // CB command accepted at edge giving cycle kk: reads kk.., writes kk+2..
   task automatic push_cb(input logic [1:0] dir, input logic lk, input logic [9:0] cbb,
                          input logic [9:0] tbb, input int len, input int kk);
      for (int i = 0; i < len; i++) begin
         ev_t e;
         e.cyc = kk + i; e.addr = cbb + 10'(i); e.mask = 4'b0;
         cb_q.push_back(e);
         e.cyc = kk + 2 + i; e.addr = tbb + 10'(i); e.mask = exp_mask(dir, lk);
         wr_q.push_back(e);
      end
      done_q.push_back((len == 0) ? kk : kk + len + 2);
   endtask

   // Called at a negedge; returns at the negedge of the first command cycle.
   // mode: 0 = push nothing, 1 = full CB expectation, 2 = first two reads only.
   task automatic start_cmd(input logic src, input logic [1:0] dir, input logic lk,
                            input logic [9:0] cbb, input logic [9:0] tbb,
                            input logic [7:0] len, input int mode, output int kk);
      ev_t e;
      chk("ready_before_accept", cmd_ready, 1);
      cmd_src = src; cmd_dir = dir; cmd_l_k_0 = lk;
      cmd_cb_base = cbb; cmd_tb_base = tbb; cmd_len = len;
      cmd_valid = 1'b1;
      kk = cyc + 1;
      if (mode == 1) push_cb(dir, lk, cbb, tbb, int'(len), kk);
      if (mode == 2) begin
         e.mask = 4'b0;
         e.cyc = kk;     e.addr = cbb;          cb_q.push_back(e);
         e.cyc = kk + 1; e.addr = cbb + 10'd1;  cb_q.push_back(e);
      end
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!cmd_ready && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) fail_now("idle_timeout");
   endtask

   always @(negedge clk) begin : monitor
      ev_t e;
      int  d;
      if (CB_ena) begin
         if (cb_q.size() == 0) fail_now("cb_unexpected");
         else begin
            e = cb_q.pop_front();
            chk("cb_cycle", cyc, e.cyc);
            chk("cb_addr", CB_addra, e.addr);
         end
      end
      if (TB_wea != 4'b0) begin
         if (wr_q.size() == 0) fail_now("wr_unexpected");
         else begin
            e = wr_q.pop_front();
            chk("wr_cycle", cyc, e.cyc);
            chk("wr_addr", TB_addra, e.addr);
            chk("wr_mask", TB_wea, e.mask);
         end
      end
      if (done) begin
         if (done_q.size() == 0) fail_now("done_unexpected");
         else begin
            d = done_q.pop_front();
            chk("done_cycle", cyc, d);
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      sys_rst_n = 1'b0; cmd_valid = 1'b0; cmd_src = 1'b0; cmd_dir = 2'b0;
      cmd_l_k_0 = 1'b0; cmd_cb_base = '0; cmd_tb_base = '0; cmd_len = '0;
      nl_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_outputs", {cmd_ready, CB_ena, TB_wea, busy, done, nl_ready,
                            TB_dina_sel, l_k_0, CB_addra, TB_addra}, 0);
      sys_rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_release", cmd_ready, 1);
      chk("idle_busy", busy, 0);

      // CB POS
      start_cmd(1'b0, 2'b01, 1'b0, 10'h010, 10'h020, 8'd4, 1, k);
      chk("pos_busy", busy, 1);
      chk("pos_sel", TB_dina_sel, 3'b001);
      wait_idle();

      // NEW, both halves
      start_cmd(1'b0, 2'b11, 1'b0, 10'h100, 10'h080, 8'd2, 1, k);
      chk("new0_sel", TB_dina_sel, 3'b011);
      chk("new0_lk", l_k_0, 0);
      @(negedge clk);
      chk("new0_sel_hold", TB_dina_sel, 3'b011);
      wait_idle();
      start_cmd(1'b0, 2'b11, 1'b1, 10'h104, 10'h090, 8'd2, 1, k);
      chk("new1_sel", TB_dina_sel, 3'b011);
      chk("new1_lk", l_k_0, 1);
      wait_idle();

      // NEG keeps ascending CB addresses
      start_cmd(1'b0, 2'b10, 1'b0, 10'h200, 10'h300, 8'd3, 1, k);
      chk("neg_sel", TB_dina_sel, 3'b010);
      wait_idle();

      // NL with bubbles; nl_valid in IDLE is ignored
      nl_valid = 1'b1;
      repeat (2) @(negedge clk);
      start_cmd(1'b1, 2'b01, 1'b0, 10'h000, 10'h055, 8'd3, 0, k);
      begin
         ev_t e;
         e.mask = 4'b1111;
         e.cyc = k + 1; e.addr = 10'h055; wr_q.push_back(e);
         e.cyc = k + 4; e.addr = 10'h056; wr_q.push_back(e);
         e.cyc = k + 5; e.addr = 10'h057; wr_q.push_back(e);
         done_q.push_back(k + 6);
      end
      chk("nl_sel", TB_dina_sel, 3'b101);
      for (int i = 0; i < 6; i++) begin
         nl_valid = nl_pat[i];
         if (i == 4) chk("nl_ready_third", nl_ready, 1);
         if (i == 5) chk("nl_ready_drop", nl_ready, 0);
         @(negedge clk);
      end
      nl_valid = 1'b0;
      wait_idle();

      // len 0 and address wrap
      start_cmd(1'b0, 2'b01, 1'b0, 10'h001, 10'h002, 8'd0, 1, k);
      wait_idle();
      start_cmd(1'b0, 2'b01, 1'b0, 10'h3FF, 10'h3FE, 8'd3, 1, k);
      wait_idle();

      // reset during the 2nd beat of a len-8 CB command
      start_cmd(1'b0, 2'b01, 1'b0, 10'h100, 10'h180, 8'd8, 2, k);
      @(negedge clk);
      #1 sys_rst_n = 1'b0;
      #1 chk("midreset_outputs", {cmd_ready, CB_ena, TB_wea, busy, done, nl_ready,
                                  TB_dina_sel, l_k_0, CB_addra, TB_addra}, 0);
      @(negedge clk);
      chk("ready_in_reset", cmd_ready, 0);
      sys_rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_midreset", cmd_ready, 1);
      start_cmd(1'b0, 2'b01, 1'b0, 10'h010, 10'h011, 8'd1, 1, k);
      wait_idle();

      // back-to-back: held cmd_valid accepted only after done
      cmd_src = 1'b0; cmd_dir = 2'b01; cmd_l_k_0 = 1'b0;
      cmd_cb_base = 10'h040; cmd_tb_base = 10'h050; cmd_len = 8'd2;
      cmd_valid = 1'b1;
      ka = cyc + 1;
      push_cb(2'b01, 1'b0, 10'h040, 10'h050, 2, ka);
      push_cb(2'b11, 1'b1, 10'h060, 10'h070, 1, ka + 6);
      @(negedge clk);
      cmd_dir = 2'b11; cmd_l_k_0 = 1'b1;
      cmd_cb_base = 10'h060; cmd_tb_base = 10'h070; cmd_len = 8'd1;
      chk("b2b_sel_a", TB_dina_sel, 3'b001);
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         if (i <= 3) chk("b2b_sel_a_hold", TB_dina_sel, 3'b001);
         if (i == 5) begin
            chk("b2b_sel_idle", TB_dina_sel, 3'b000);
            chk("b2b_ready_gap", cmd_ready, 1);
         end
      end
      @(negedge clk);
      chk("b2b_sel_b", TB_dina_sel, 3'b011);
      chk("b2b_busy_b", busy, 1);
      cmd_valid = 1'b0;
      wait_idle();

      repeat (3) @(negedge clk);
      chk("cb_queue_empty", cb_q.size(), 0);
      chk("wr_queue_empty", wr_q.size(), 0);
      chk("done_queue_empty", done_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
